nmr_bstrm_mc: RTL and testbench

Multi-channel, nested-loop successor to the single-output NMR bitstream sequencer. Fetches 128-bit command words from on-chip SRAM, plays each as initial-delay / pulse / end-delay phases onto a per-command mask of `NCH` output channels, and supports nested hardware loops, abort and error reporting. It sits between the HPS-loaded sequence RAM and the NMR TX/RX gating lines.

---
 rtl/nmr_bstrm_pkg.sv | 27 ++
 rtl/nmr_bstrm_loop_stack.sv | 65 ++++++
 rtl/nmr_bstrm_mc.sv | 240 ++++++++++++++++++++++++
 tb/tb_nmr_bstrm_mc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmr_bstrm_pkg.sv
// nmr_bstrm_pkg: command word layout, flag bits and sequencer states
// shared by the multi-channel NMR bitstream sequencer.
package nmr_bstrm_pkg;

    localparam int MASK_LSB = 8;
    localparam int LOOP_LSB = 16;
    localparam int IDLY_LSB = 32;
    localparam int PLS_LSB  = 64;
    localparam int EDLY_LSB = 96;

    localparam int F_LOOP_END   = 0;
    localparam int F_LOOP_START = 1;
    localparam int F_END        = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_IDLY,
        S_PLS,
        S_EDLY,
        S_EVAL,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/nmr_bstrm_loop_stack.sv
// nmr_bstrm_loop_stack: LIFO of {loop head address, remaining count}
// with push, pop and decrement-top; one operation per cycle.
module nmr_bstrm_loop_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic          dec,
    input  logic [AW-1:0] push_addr,
    input  logic [CW-1:0] push_cnt,
    output logic [AW-1:0] top_addr,
    output logic [CW-1:0] top_cnt,
    output logic          full,
    output logic          empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [CW-1:0] cnt_mem  [DEPTH];
    logic [SW-1:0] sp;
    logic [IW-1:0] top_idx;
    logic [IW-1:0] push_idx;
    logic          do_push;
    logic          do_pop;
    logic          do_dec;

    assign top_idx  = IW'(sp - 1'b1);
    assign push_idx = IW'(sp);
    assign empty    = (sp == '0);
    assign full     = (sp == SW'(DEPTH));
    assign top_addr = addr_mem[top_idx];
    assign top_cnt  = cnt_mem[top_idx];

    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr && !push;
    assign do_dec  = dec && !empty && !clr && !push && !pop;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + 1'b1;
        end else if (do_pop) begin
            sp <= sp - 1'b1;
        end
    end

    // Entry storage needs no reset: only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            addr_mem[push_idx] <= push_addr;
            cnt_mem[push_idx]  <= push_cnt;
        end else if (!rst && do_dec) begin
            cnt_mem[top_idx] <= top_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/nmr_bstrm_mc.sv
// nmr_bstrm_mc: fetches 128-bit commands from SRAM and plays them as
// delay / pulse / delay phases on a channel mask, with nested loops.
module nmr_bstrm_mc
    import nmr_bstrm_pkg::*;
#(
    parameter int NCH               = 4,
    parameter int LOOP_DEPTH        = 4,
    parameter int IDLY_WIDTH        = 32,
    parameter int PLS_WIDTH         = 32,
    parameter int EDLY_WIDTH        = 32,
    parameter int LOOP_WIDTH        = 16,
    parameter int SRAM_ADDR_WIDTH   = 8,
    parameter int SRAM_DAT_WIDTH    = 128,
    parameter int SRAM_BYTEEN_WIDTH = 16,
    parameter int RD_LAT            = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic                         ABORT,
    input  logic [SRAM_ADDR_WIDTH-1:0]   START_ADDR,
    output logic                         DONE,
    output logic                         BUSY,
    output logic                         ERR,
    output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
    output logic                         SRAM_CS,
    output logic                         SRAM_CLKEN,
    output logic                         SRAM_WR,
    input  logic [SRAM_DAT_WIDTH-1:0]    SRAM_RD_DAT,
    output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
    output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
    output logic [NCH-1:0]               OUT
);

    localparam int CW0 = (IDLY_WIDTH > PLS_WIDTH) ? IDLY_WIDTH : PLS_WIDTH;
    localparam int CW  = (CW0 > EDLY_WIDTH) ? CW0 : EDLY_WIDTH;
    localparam int AW  = SRAM_ADDR_WIDTH;
    localparam int LW  = LOOP_WIDTH;

    state_t                    state_q, state_d, ph;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic [SRAM_DAT_WIDTH-1:0] word_q, src_w;
    logic                      word_ld;
    logic [NCH-1:0]            out_q, out_d;
    logic                      err_q, err_d;
    logic                      reent_q, reent_d;
    logic                      st_clr, st_push, st_pop, st_dec;
    logic                      st_full, st_empty;
    logic [LW-1:0]             push_cnt, loop_v, lc, top_cnt;
    logic [AW-1:0]             top_addr;
    logic [CW-1:0]             idly, pls, edly;
    logic                      f_ls, f_le, f_end;
    logic                      use_i, use_p, use_e;
    logic                      unused;

    function automatic state_t pick(
        input logic [CW-1:0] i,
        input logic [CW-1:0] p,
        input logic [CW-1:0] e,
        input logic          ui,
        input logic          up,
        input logic          ue
    );
        pick = S_EVAL;
        if (ue && e != '0) pick = S_EDLY;
        if (up && p != '0) pick = S_PLS;
        if (ui && i != '0) pick = S_IDLY;
    endfunction

    function automatic logic [CW-1:0] len_m1(
        input state_t        s,
        input logic [CW-1:0] i,
        input logic [CW-1:0] p,
        input logic [CW-1:0] e
    );
        unique case (s)
            S_IDLY:  len_m1 = i - 1'b1;
            S_PLS:   len_m1 = p - 1'b1;
            S_EDLY:  len_m1 = e - 1'b1;
            default: len_m1 = '0;
        endcase
    endfunction

    // The word is still on the SRAM bus during the last WAIT cycle.
    assign src_w = (state_q == S_WAIT) ? SRAM_RD_DAT : word_q;
    assign idly  = CW'(src_w[IDLY_LSB +: IDLY_WIDTH]);
    assign pls   = CW'(src_w[PLS_LSB +: PLS_WIDTH]);
    assign edly  = CW'(src_w[EDLY_LSB +: EDLY_WIDTH]);

    assign loop_v = word_q[LOOP_LSB +: LW];
    assign lc     = (loop_v == '0) ? LW'(1) : loop_v;
    assign f_ls   = word_q[F_LOOP_START] && !reent_q;
    assign f_le   = word_q[F_LOOP_END];
    assign f_end  = word_q[F_END];

    assign use_i = (state_q == S_WAIT);
    assign use_p = use_i || (state_q == S_IDLY);
    assign use_e = use_p || (state_q == S_PLS);
    assign ph    = pick(idly, pls, edly, use_i, use_p, use_e);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        word_ld  = 1'b0;
        err_d    = err_q;
        reent_d  = reent_q;
        st_clr   = 1'b0;
        st_push  = 1'b0;
        st_pop   = 1'b0;
        st_dec   = 1'b0;
        push_cnt = lc;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_FETCH;
                    addr_d  = START_ADDR;
                    err_d   = 1'b0;
                    reent_d = 1'b0;
                    st_clr  = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
                cnt_d   = CW'(RD_LAT - 1);
            end
            S_WAIT, S_IDLY, S_PLS, S_EDLY: begin
                if (cnt_q == '0) begin
                    word_ld = (state_q == S_WAIT);
                    state_d = ph;
                    cnt_d   = len_m1(ph, idly, pls, edly);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EVAL: begin
                state_d = S_FETCH;
                addr_d  = addr_q + 1'b1;
                reent_d = 1'b0;
                if (f_ls && st_full) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    st_clr  = 1'b1;
                end else if (f_end) begin
                    state_d = S_DONE;
                    st_clr  = 1'b1;
                end else if (f_ls && f_le) begin
                    // Single-word loop: push already counts this pass.
                    if (lc > LW'(1)) begin
                        st_push  = 1'b1;
                        push_cnt = lc - 1'b1;
                        addr_d   = addr_q;
                        reent_d  = 1'b1;
                    end
                end else if (f_ls) begin
                    st_push = 1'b1;
                end else if (f_le) begin
                    if (st_empty) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (top_cnt > LW'(1)) begin
                        st_dec  = 1'b1;
                        addr_d  = top_addr;
                        reent_d = 1'b1;
                    end else begin
                        st_pop = 1'b1;
                    end
                end
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
        if (ABORT) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            err_d   = err_q;
            reent_d = 1'b0;
            word_ld = 1'b0;
            st_clr  = 1'b1;
            st_push = 1'b0;
            st_pop  = 1'b0;
            st_dec  = 1'b0;
        end
        out_d = (state_d == S_PLS) ? src_w[MASK_LSB +: NCH] : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            reent_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            err_q   <= err_d;
            reent_q <= reent_d;
            if (word_ld) word_q <= SRAM_RD_DAT;
        end
    end

    nmr_bstrm_loop_stack #(
        .DEPTH (LOOP_DEPTH),
        .AW    (AW),
        .CW    (LW)
    ) u_stack (
        .clk       (CLK),
        .rst       (RST),
        .clr       (st_clr),
        .push      (st_push),
        .pop       (st_pop),
        .dec       (st_dec),
        .push_addr (addr_q),
        .push_cnt  (push_cnt),
        .top_addr  (top_addr),
        .top_cnt   (top_cnt),
        .full      (st_full),
        .empty     (st_empty)
    );

    assign unused = ^word_q;

    assign OUT         = out_q;
    assign DONE        = (state_q == S_DONE);
    assign BUSY        = (state_q != S_IDLE);
    assign ERR         = err_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_CS     = (state_q == S_FETCH);
    assign SRAM_CLKEN  = (state_q == S_FETCH);
    assign SRAM_WR     = 1'b0;
    assign SRAM_WR_DAT = '0;
    assign SRAM_BYTEEN = '1;

endmodule

// File: tb/tb_nmr_bstrm_mc.sv
// tb_nmr_bstrm_mc: table of whole-program runs with hand-computed pulse
// timing, plus directed abort / reset / busy-start sequences.
module tb_nmr_bstrm_mc;

    localparam logic [7:0] FLE = 8'h01;
    localparam logic [7:0] FLS = 8'h02;
    localparam logic [7:0] FE  = 8'h04;
    localparam int NV = 6;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic         ABORT = 1'b0;
    logic [7:0]   START_ADDR = '0;
    logic         DONE, BUSY, ERR;
    logic [7:0]   SRAM_ADDR;
    logic         SRAM_CS, SRAM_CLKEN, SRAM_WR;
    logic [127:0] SRAM_RD_DAT = '0;
    logic [127:0] SRAM_WR_DAT;
    logic [15:0]  SRAM_BYTEEN;
    logic [3:0]   OUT;

    logic [127:0] mem [256];

    int errors = 0;
    int checks = 0;

    int r_done_k, r_end_k, r_dn, r_err, r_ncs, r_last;
    int r_hi [4];
    int r_pul [4];
    int r_rise [4];

    typedef struct {
        int             prog;
        logic [7:0]     sa;
        int             done_k;
        int             end_k;
        int             dn;
        int             err;
        int             ncs;
        int             last;
        logic [3:0][7:0] hi;
        logic [3:0][7:0] pul;
        logic [3:0][7:0] rise;
    } vec_t;

    vec_t tv [NV];

    nmr_bstrm_mc dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .ABORT       (ABORT),
        .START_ADDR  (START_ADDR),
        .DONE        (DONE),
        .BUSY        (BUSY),
        .ERR         (ERR),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_CS     (SRAM_CS),
        .SRAM_CLKEN  (SRAM_CLKEN),
        .SRAM_WR     (SRAM_WR),
        .SRAM_RD_DAT (SRAM_RD_DAT),
        .SRAM_WR_DAT (SRAM_WR_DAT),
        .SRAM_BYTEEN (SRAM_BYTEEN),
        .OUT         (OUT)
    );

    always #5 CLK = ~CLK;

    // One-cycle-latency synchronous SRAM.
    always @(posedge CLK) begin
        if (SRAM_CS && SRAM_CLKEN) SRAM_RD_DAT <= mem[SRAM_ADDR];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [127:0] w(
        input logic [31:0] e,
        input logic [31:0] p,
        input logic [31:0] i,
        input logic [15:0] l,
        input logic [7:0]  m,
        input logic [7:0]  f
    );
        return {e, p, i, l, m, f};
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(input int id);
        for (int a = 0; a < 256; a++) mem[a] = '0;
        case (id)
            0: mem[0] = w(5, 5, 5, 0, 8'h1, FE);
            1: begin
                mem[0] = w(0, 2, 0, 0, 8'h1, 8'h0);
                mem[1] = w(0, 8, 0, 4, 8'h3, FLS);
                mem[2] = w(0, 8, 0, 0, 8'h4, FLE);
                mem[3] = w(0, 10, 0, 0, 8'h8, FE);
            end
            2: begin
                mem[0] = w(0, 1, 0, 3, 8'h1, FLS);
                mem[1] = w(0, 2, 0, 2, 8'h2, FLS | FLE);
                mem[2] = w(0, 1, 0, 0, 8'h4, FLE);
                mem[3] = w(0, 1, 0, 0, 8'h8, FE);
            end
            3: for (int a = 0; a < 5; a++) mem[a] = w(0, 1, 0, 2, 8'h1, FLS);
            4: begin
                mem[255] = w(2, 0, 3, 0, 8'h1, 8'h0);
                mem[0]   = w(0, 4, 0, 0, 8'h2, FE);
            end
            default: ;
        endcase
    endtask

    // Cycle k=1 is the FETCH cycle after START is sampled.
    task automatic run(input logic [7:0] sa);
        int k;
        logic fin;
        logic [3:0] prev;
        r_done_k = 0; r_end_k = 0; r_dn = 0;
        r_err = 0; r_ncs = 0; r_last = 0;
        for (int c = 0; c < 4; c++) begin
            r_hi[c] = 0; r_pul[c] = 0; r_rise[c] = 0;
        end
        prev = '0;
        @(negedge CLK);
        START_ADDR = sa;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        k = 1;
        fin = 1'b0;
        while (!fin && k <= 2000) begin
            if (SRAM_CS) begin
                r_ncs++;
                r_last = int'(SRAM_ADDR);
            end
            if (DONE) begin
                r_dn++;
                r_done_k = k;
            end
            if (ERR) r_err = 1;
            for (int c = 0; c < 4; c++) begin
                if (OUT[c]) r_hi[c]++;
                if (OUT[c] && !prev[c]) begin
                    r_pul[c]++;
                    if (r_rise[c] == 0) r_rise[c] = k;
                end
            end
            prev = OUT;
            if (!BUSY) begin
                fin = 1'b1;
                r_end_k = k;
            end else begin
                @(negedge CLK);
                k++;
            end
        end
        if (!fin) chk("run_timeout", 1, 0);
    endtask

    initial begin
        int n;
        tv[0] = '{prog:0, sa:8'd0, done_k:19, end_k:20, dn:1, err:0,
                  ncs:1, last:0,
                  hi:{8'd0, 8'd0, 8'd0, 8'd5},
                  pul:{8'd0, 8'd0, 8'd0, 8'd1},
                  rise:{8'd0, 8'd0, 8'd0, 8'd8}};
        tv[1] = '{prog:1, sa:8'd0, done_k:107, end_k:108, dn:1, err:0,
                  ncs:10, last:3,
                  hi:{8'd10, 8'd32, 8'd32, 8'd34},
                  pul:{8'd1, 8'd4, 8'd4, 8'd5},
                  rise:{8'd96, 8'd19, 8'd8, 8'd3}};
        tv[2] = '{prog:2, sa:8'd0, done_k:59, end_k:60, dn:1, err:0,
                  ncs:13, last:3,
                  hi:{8'd1, 8'd3, 8'd12, 8'd3},
                  pul:{8'd1, 8'd3, 8'd6, 8'd3},
                  rise:{8'd57, 8'd17, 8'd7, 8'd3}};
        tv[3] = '{prog:3, sa:8'd0, done_k:0, end_k:22, dn:0, err:1,
                  ncs:5, last:4,
                  hi:{8'd0, 8'd0, 8'd0, 8'd5},
                  pul:{8'd0, 8'd0, 8'd0, 8'd5},
                  rise:{8'd0, 8'd0, 8'd0, 8'd3}};
        tv[4] = tv[0];
        tv[5] = '{prog:4, sa:8'd255, done_k:16, end_k:17, dn:1, err:0,
                  ncs:2, last:0,
                  hi:{8'd0, 8'd0, 8'd4, 8'd0},
                  pul:{8'd0, 8'd0, 8'd1, 8'd0},
                  rise:{8'd0, 8'd0, 8'd11, 8'd0}};

        for (int a = 0; a < 256; a++) mem[a] = '0;
        repeat (3) @(negedge CLK);
        chk("rst_out", OUT, 0);
        chk("rst_done", DONE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_err", ERR, 0);
        chk("rst_cs", SRAM_CS, 0);
        chk("rst_clken", SRAM_CLKEN, 0);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rd_only_wr", SRAM_WR, 0);
        chk("rd_only_wdat", (SRAM_WR_DAT == '0), 1);
        chk("rd_only_byteen", SRAM_BYTEEN, 16'hffff);
        RST = 1'b0;

        for (int i = 0; i < NV; i++) begin
            load(tv[i].prog);
            run(tv[i].sa);
            chk($sformatf("v%0d done_k", i), r_done_k, tv[i].done_k);
            chk($sformatf("v%0d end_k", i), r_end_k, tv[i].end_k);
            chk($sformatf("v%0d done_n", i), r_dn, tv[i].dn);
            chk($sformatf("v%0d err", i), r_err, tv[i].err);
            chk($sformatf("v%0d ncs", i), r_ncs, tv[i].ncs);
            chk($sformatf("v%0d last_addr", i), r_last, tv[i].last);
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("v%0d hi%0d", i, c), r_hi[c], tv[i].hi[c]);
                chk($sformatf("v%0d pul%0d", i, c), r_pul[c], tv[i].pul[c]);
                chk($sformatf("v%0d rise%0d", i, c), r_rise[c], tv[i].rise[c]);
            end
        end

        // START while busy is ignored, then ABORT mid-pulse.
        load(0);
        @(negedge CLK);
        START_ADDR = 8'd0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        START_ADDR = 8'h55;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        chk("busy_start_out", OUT, 4'h1);
        chk("busy_start_addr", SRAM_ADDR, 0);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        chk("abort_out", OUT, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        n = 0;
        repeat (20) begin
            @(negedge CLK);
            if (SRAM_CS) n++;
            if (DONE) n++;
        end
        chk("abort_quiet", n, 0);
        run(8'd0);
        chk("post_abort done_k", r_done_k, 19);
        chk("post_abort hi0", r_hi[0], 5);

        // Sticky ERR is cleared by reset.
        load(3);
        run(8'd0);
        chk("err_sticky", ERR, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_clears_err", ERR, 0);

        // Reset in the middle of a pulse.
        load(1);
        @(negedge CLK);
        START_ADDR = 8'd0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        chk("mid_out", OUT, 4'h3);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_out", OUT, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_done", DONE, 0);
        chk("midrst_cs", SRAM_CS, 0);
        chk("midrst_clken", SRAM_CLKEN, 0);
        chk("midrst_addr", SRAM_ADDR, 0);
        RST = 1'b0;
        run(8'd0);
        chk("post_rst done_k", r_done_k, 107);
        chk("post_rst hi3", r_hi[3], 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
